// File: rtl/clk_rate_generator.sv
// Four independent square-wave rate channels derived from one clock by half-period counters.
// Each channel also emits a registered one-cycle pulse whenever its output rises.
module clk_rate_generator #(
    parameter int HALF0 = 25000000,
    parameter int HALF1 = 12500000,
    parameter int HALF2 = 6250000,
    parameter int HALF3 = 3125000,
    parameter int CNT_W = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic rise0,
    output logic rise1,
    output logic rise2,
    output logic rise3
);

    localparam int HALF [4] = '{HALF0, HALF1, HALF2, HALF3};

    logic [3:0] w_out;
    logic [3:0] w_rise;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            // A half-period must fit in the counter as HALF-1 and be at least one cycle.
            if (HALF[gi] < 1 || (64'(HALF[gi]) >> CNT_W) != 64'd0) begin : g_bad_half
                $error("clk_rate_generator: half-period out of range for CNT_W");
            end

            localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF[gi] - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_out;
            logic             r_rise;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    r_cnt  <= '0;
                    r_out  <= 1'b0;
                    r_rise <= 1'b0;
                end else if (enable) begin
                    if (r_cnt == LAST) begin
                        r_cnt  <= '0;
                        r_out  <= ~r_out;
                        r_rise <= ~r_out;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_rise <= 1'b0;
                    end
                end else begin
                    r_rise <= 1'b0;
                end
            end

            assign w_out[gi]  = r_out;
            assign w_rise[gi] = r_rise;
        end
    endgenerate

    assign out0  = w_out[0];
    assign out1  = w_out[1];
    assign out2  = w_out[2];
    assign out3  = w_out[3];
    assign rise0 = w_rise[0];
    assign rise1 = w_rise[1];
    assign rise2 = w_rise[2];
    assign rise3 = w_rise[3];

endmodule

// File: tb/tb_clk_rate_generator.sv
// Directed bench for clk_rate_generator: two instances with small half-periods driven in lockstep.
module tb_clk_rate_generator;

    localparam int HA [4] = '{2, 3, 4, 5};
    localparam int HB [4] = '{4, 3, 1, 5};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;

    logic a_o0, a_o1, a_o2, a_o3, a_r0, a_r1, a_r2, a_r3;
    logic b_o0, b_o1, b_o2, b_o3, b_r0, b_r1, b_r2, b_r3;
    logic [3:0] a_out, a_rise, b_out, b_rise;

    assign a_out  = {a_o3, a_o2, a_o1, a_o0};
    assign a_rise = {a_r3, a_r2, a_r1, a_r0};
    assign b_out  = {b_o3, b_o2, b_o1, b_o0};
    assign b_rise = {b_r3, b_r2, b_r1, b_r0};

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clk_rate_generator #(.HALF0(2), .HALF1(3), .HALF2(4), .HALF3(5), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .out0(a_o0), .out1(a_o1), .out2(a_o2), .out3(a_o3),
        .rise0(a_r0), .rise1(a_r1), .rise2(a_r2), .rise3(a_r3)
    );

    clk_rate_generator #(.HALF0(4), .HALF1(3), .HALF2(1), .HALF3(5), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .out0(b_o0), .out1(b_o1), .out2(b_o2), .out3(b_o3),
        .rise0(b_r0), .rise1(b_r1), .rise2(b_r2), .rise3(b_r3)
    );

    // Expected outputs after k enabled edges since reset/clear release.
    function automatic logic [3:0] exp_vec(input int k, input bit is_b, input bit want_rise);
        logic [3:0] v;
        int h;
        v = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            h = is_b ? HB[c] : HA[c];
            if (want_rise)
                v[c] = (k > 0) && (k % h == 0) && ((k / h) % 2 == 1);
            else
                v[c] = ((k / h) % 2) == 1;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({a_out, a_rise, b_out, b_rise} !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got a_out=%b a_rise=%b b_out=%b b_rise=%b want all 0",
                         i, a_out, a_rise, b_out, b_rise);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (a_out !== 4'b0000 || a_rise !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_a got out=%b rise=%b want 0000 0000", a_out, a_rise);
        end
        n_checks++;
        if (b_out !== exp_vec(1, 1, 0) || b_rise !== exp_vec(1, 1, 1)) begin
            n_fail++;
            $display("FAIL reset_release_b got out=%b rise=%b want %b %b",
                     b_out, b_rise, exp_vec(1, 1, 0), exp_vec(1, 1, 1));
        end
    endtask

    task automatic test_rate();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (a_out !== exp_vec(k, 0, 0) || a_rise !== exp_vec(k, 0, 1)) begin
                n_fail++;
                $display("FAIL rate_a k=%0d got out=%b rise=%b want %b %b",
                         k, a_out, a_rise, exp_vec(k, 0, 0), exp_vec(k, 0, 1));
            end
            n_checks++;
            if (b_out !== exp_vec(k, 1, 0) || b_rise !== exp_vec(k, 1, 1)) begin
                n_fail++;
                $display("FAIL rate_b k=%0d got out=%b rise=%b want %b %b",
                         k, b_out, b_rise, exp_vec(k, 1, 0), exp_vec(k, 1, 1));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int k = 1; k <= 6; k++) tick();
        n_checks++;
        if (b_o0 !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_pre got b_out0=%b want 1", b_o0);
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (a_out !== exp_vec(6, 0, 0) || b_out !== exp_vec(6, 1, 0) ||
                a_rise !== 4'b0000 || b_rise !== 4'b0000) begin
                n_fail++;
                $display("FAIL freeze_hold cyc=%0d got a_out=%b b_out=%b a_rise=%b b_rise=%b want %b %b 0000 0000",
                         i, a_out, b_out, a_rise, b_rise, exp_vec(6, 0, 0), exp_vec(6, 1, 0));
            end
        end
        enable = 1'b1;
        for (int k = 7; k <= 16; k++) begin
            tick();
            n_checks++;
            if (a_out !== exp_vec(k, 0, 0) || a_rise !== exp_vec(k, 0, 1) ||
                b_out !== exp_vec(k, 1, 0) || b_rise !== exp_vec(k, 1, 1)) begin
                n_fail++;
                $display("FAIL freeze_resume k=%0d got a=%b/%b b=%b/%b want %b/%b %b/%b",
                         k, a_out, a_rise, b_out, b_rise, exp_vec(k, 0, 0), exp_vec(k, 0, 1),
                         exp_vec(k, 1, 0), exp_vec(k, 1, 1));
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int k = 1; k <= 4; k++) tick();
        n_checks++;
        if (a_o1 !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre got a_out1=%b want 1", a_o1);
        end
        clear = 1'b1;
        tick();
        n_checks++;
        if ({a_out, a_rise, b_out, b_rise} !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_apply got a_out=%b a_rise=%b b_out=%b b_rise=%b want all 0",
                     a_out, a_rise, b_out, b_rise);
        end
        clear = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (a_out !== exp_vec(k, 0, 0) || a_rise !== exp_vec(k, 0, 1) ||
                b_out !== exp_vec(k, 1, 0) || b_rise !== exp_vec(k, 1, 1)) begin
                n_fail++;
                $display("FAIL clear_restart k=%0d got a=%b/%b b=%b/%b want %b/%b %b/%b",
                         k, a_out, a_rise, b_out, b_rise, exp_vec(k, 0, 0), exp_vec(k, 0, 1),
                         exp_vec(k, 1, 0), exp_vec(k, 1, 1));
            end
        end
    endtask

    task automatic test_minimum();
        logic [3:0] want_o;
        logic [3:0] want_r;
        want_o = 4'b0101;
        want_r = 4'b0101;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (b_o2 !== want_o[k-1] || b_r2 !== want_r[k-1]) begin
                n_fail++;
                $display("FAIL minimum k=%0d got out2=%b rise2=%b want %b %b",
                         k, b_o2, b_r2, want_o[k-1], want_r[k-1]);
            end
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (b_o2 !== 1'b1 || b_r2 !== 1'b0) begin
            n_fail++;
            $display("FAIL minimum_freeze got out2=%b rise2=%b want 1 0", b_o2, b_r2);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (b_o2 !== 1'b0 || b_r2 !== 1'b0) begin
            n_fail++;
            $display("FAIL minimum_resume got out2=%b rise2=%b want 0 0", b_o2, b_r2);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int k = 1; k <= 9; k++) tick();
        n_checks++;
        if (a_o3 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre got a_out3=%b want 1", a_o3);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({a_out, a_rise, b_out, b_rise} !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrun_reset got a_out=%b a_rise=%b b_out=%b b_rise=%b want all 0",
                     a_out, a_rise, b_out, b_rise);
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (a_out !== exp_vec(k, 0, 0) || a_rise !== exp_vec(k, 0, 1)) begin
                n_fail++;
                $display("FAIL midrun_restart k=%0d got out=%b rise=%b want %b %b",
                         k, a_out, a_rise, exp_vec(k, 0, 0), exp_vec(k, 0, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_freeze();
        test_clear();
        test_minimum();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
